// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared encodings and helpers for stream_mux_rr.
// The lock FSM states are used only when STREAM_MUX_LAST_LOCK_EN is defined.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Callers guarantee 0 <= v < n.
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - producer/consumer handshake bundle for stream_mux_rr.
// in_last/out_last exist only when STREAM_MUX_LAST_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
);
  import stream_mux_pkg::*;

  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_valid;
  logic                   out_ready;
`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [N_CH-1:0]        in_last;
  logic                   out_last;

  modport master (
    output in_data, in_valid, in_last, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_last
  );
`else
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin grant search.
// Picks the first set request starting at ptr_i and wrapping modulo N_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             grant_exists_o
);

  function automatic logic [SEL_W-1:0] wrap_idx(input int base, input int off);
    int k;
    k = base + off;
    if (k >= N_CH) k = k - N_CH;
    return SEL_W'(k);
  endfunction

  always_comb begin
    grant_o        = '0;
    grant_exists_o = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_exists_o && req_i[wrap_idx(int'(ptr_i), i)]) begin
        grant_o        = wrap_idx(int'(ptr_i), i);
        grant_exists_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux with fixed/round-robin arbitration and a registered output.
// Optional packet locking on in_last is enabled with STREAM_MUX_LAST_LOCK_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_mux_rr_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              can_load;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_exists;
  logic              fixed_exists;
  logic [SEL_W-1:0]  arb_grant;
  logic              arb_exists;
  logic [SEL_W-1:0]  grant;
  logic              grant_exists;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i          (bus.in_valid),
    .ptr_i          (rr_ptr_q),
    .grant_o        (rr_grant),
    .grant_exists_o (rr_exists)
  );

  assign can_load = ~out_valid_q | bus.out_ready;

  // An out-of-range sel never grants, even for non-power-of-two N_CH.
  always_comb begin
    fixed_exists = 1'b0;
    if (int'(bus.sel) < N_CH) fixed_exists = bus.in_valid[bus.sel];
    if (bus.mode == MODE_RR) begin
      arb_grant  = rr_grant;
      arb_exists = rr_exists;
    end else begin
      arb_grant  = bus.sel;
      arb_exists = fixed_exists;
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  lock_state_e      lock_state_q, lock_state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_q <= IDLE;
      lock_ch_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    if (xfer) begin
      case (lock_state_q)
        IDLE: begin
          if (!bus.in_last[grant]) begin
            lock_state_d = LOCKED;
            lock_ch_d    = grant;
          end
        end
        LOCKED: begin
          if (bus.in_last[grant]) lock_state_d = IDLE;
        end
        default: lock_state_d = IDLE;
      endcase
    end
  end

  // While locked, the packet owner keeps the grant regardless of mode or sel.
  always_comb begin
    if (lock_state_q == LOCKED) begin
      grant        = lock_ch_q;
      grant_exists = bus.in_valid[lock_ch_q];
    end else begin
      grant        = arb_grant;
      grant_exists = arb_exists;
    end
  end
`else
  assign grant        = arb_grant;
  assign grant_exists = arb_exists;
`endif

  assign xfer = grant_exists & can_load;

  always_comb begin
    sel_data     = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data       = bus.in_data[i*DATA_W +: DATA_W];
        bus.in_ready[i] = xfer;
      end
    end
  end

  // Moving the pointer on every round-robin transfer also lands on lock_ch+1 at packet end.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last_d  = bus.in_last[grant];
`endif
      if (bus.mode == MODE_RR) rr_ptr_d = SEL_W'(mod_inc(int'(grant), N_CH));
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule
